// File: rtl/ldm_seq_pkg.sv
// Shared encodings and helpers for the LDM/STM block-transfer sequencer.
package ldm_seq_pkg;

  localparam int unsigned MAX_NREG = 64;

  // Addressing mode as {P,U}.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } ldm_mode_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Instruction control flags as presented upstream.
  typedef struct packed {
    logic p;
    logic u;
    logic l;
    logic w;
  } ldm_ctrl_t;

  function automatic int unsigned rc_width(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_NREG-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_NREG; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/ldm_seq_if.sv
// Instruction and memory-beat signals between decode/execute and the LDM/STM sequencer.
interface ldm_seq_if #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned ADDR_W = 32
);
  import ldm_seq_pkg::*;

  localparam int unsigned RC_W = rc_width(NREG);

  logic              i_ldm_vld;
  logic              i_ldm_p;
  logic              i_ldm_u;
  logic              i_ldm_l;
  logic              i_ldm_w;
  logic [NREG-1:0]   i_reglist;
  logic              i_mem_rdy;
  logic              o_ldm_hold;
  logic              o_ldm_mem_vld;
  logic [RC_W-1:0]   o_ldm_reg_code;
  logic [ADDR_W-1:0] o_ldm_offset;
  logic              o_ldm_l;
  logic              o_ldm_last;
  logic              o_ldm_flushreq;
  logic              o_ldm_wb_vld;
  logic [ADDR_W-1:0] o_ldm_wb_offset;

  modport slave (
    input  i_ldm_vld, i_ldm_p, i_ldm_u, i_ldm_l, i_ldm_w, i_reglist, i_mem_rdy,
    output o_ldm_hold, o_ldm_mem_vld, o_ldm_reg_code, o_ldm_offset, o_ldm_l,
           o_ldm_last, o_ldm_flushreq, o_ldm_wb_vld, o_ldm_wb_offset
  );

  modport master (
    output i_ldm_vld, i_ldm_p, i_ldm_u, i_ldm_l, i_ldm_w, i_reglist, i_mem_rdy,
    input  o_ldm_hold, o_ldm_mem_vld, o_ldm_reg_code, o_ldm_offset, o_ldm_l,
           o_ldm_last, o_ldm_flushreq, o_ldm_wb_vld, o_ldm_wb_offset
  );

endinterface

// File: rtl/ldm_prienc.sv
// Lowest-set-bit priority encoder over the remaining register mask.
module ldm_prienc #(
  parameter int unsigned NREG = 16,
  parameter int unsigned RC_W = 4
) (
  input  logic [NREG-1:0] mask,
  output logic [RC_W-1:0] idx,
  output logic [NREG-1:0] clr,
  output logic            single
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (mask[i]) idx = RC_W'(i);
    end
  end

  assign clr    = mask & (~mask + NREG'(1));
  assign single = (mask != '0) && ((mask & (mask - NREG'(1))) == '0);

endmodule

// File: rtl/ldm_seq.sv
// LDM/STM block-transfer sequencer: one memory beat per listed register, lowest first,
// with base-writeback strobe and PC-load flush request.
module ldm_seq
  import ldm_seq_pkg::*;
#(
  parameter int unsigned NREG       = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  ldm_seq_if.slave  bus
);

  localparam int unsigned RC_W = rc_width(NREG);
  localparam int unsigned N_W  = $clog2(NREG + 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  logic [0:0]        state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] wb_pend_q, wb_pend_d;
  logic [ADDR_W-1:0] wb_offset_q, wb_offset_d;
  logic              l_q, l_d;
  logic              w_q, w_d;
  logic              pc_q, pc_d;
  logic              wb_vld_q, wb_vld_d;

  logic [RC_W-1:0]   idx_c;
  logic [NREG-1:0]   clr_c;
  logic              single_c;
  logic              busy_c, fire_c, last_fire_c, hold_c, accept_c;
  ldm_ctrl_t         ctrl_in;
  logic [N_W-1:0]    n_c;
  logic [ADDR_W-1:0] span_c, start_c;

  ldm_prienc #(
    .NREG (NREG),
    .RC_W (RC_W)
  ) u_prienc (
    .mask   (mask_q),
    .idx    (idx_c),
    .clr    (clr_c),
    .single (single_c)
  );

  assign ctrl_in.p = bus.i_ldm_p;
  assign ctrl_in.u = bus.i_ldm_u;
  assign ctrl_in.l = bus.i_ldm_l;
  assign ctrl_in.w = bus.i_ldm_w;

  assign busy_c      = (state_q == ST_BUSY);
  assign fire_c      = busy_c && bus.i_mem_rdy && en;
  assign last_fire_c = fire_c && single_c;
  assign hold_c      = busy_c && !last_fire_c;
  assign accept_c    = en && bus.i_ldm_vld && !hold_c;

  assign n_c    = N_W'(popcount(MAX_NREG'(bus.i_reglist)));
  assign span_c = ADDR_W'(n_c) * STRIDE;

  // Lowest-addressed beat relative to the base for each addressing mode.
  always_comb begin
    start_c = '0;
    case (ldm_mode_e'({ctrl_in.p, ctrl_in.u}))
      MODE_IA: start_c = '0;
      MODE_IB: start_c = STRIDE;
      MODE_DA: start_c = STRIDE - span_c;
      MODE_DB: start_c = '0 - span_c;
      default: start_c = '0;
    endcase
  end

  // Next state: beat retirement first, then a (possibly same-cycle) new accept.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    offset_d    = offset_q;
    wb_pend_d   = wb_pend_q;
    wb_offset_d = wb_offset_q;
    l_d         = l_q;
    w_d         = w_q;
    pc_d        = pc_q;
    wb_vld_d    = 1'b0;

    if (fire_c) begin
      mask_d   = mask_q & ~clr_c;
      offset_d = offset_q + STRIDE;
      if (single_c) begin
        state_d = ST_IDLE;
        if (w_q) begin
          wb_vld_d    = 1'b1;
          wb_offset_d = wb_pend_q;
        end
      end
    end

    if (accept_c) begin
      l_d       = ctrl_in.l;
      w_d       = ctrl_in.w;
      pc_d      = bus.i_reglist[NREG-1];
      wb_pend_d = ctrl_in.u ? span_c : ('0 - span_c);
      if (n_c != '0) begin
        state_d  = ST_BUSY;
        mask_d   = bus.i_reglist;
        offset_d = start_c;
      end else if (ctrl_in.w) begin
        wb_vld_d    = 1'b1;
        wb_offset_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      offset_q    <= '0;
      wb_pend_q   <= '0;
      wb_offset_q <= '0;
      l_q         <= 1'b0;
      w_q         <= 1'b0;
      pc_q        <= 1'b0;
      wb_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      offset_q    <= offset_d;
      wb_pend_q   <= wb_pend_d;
      wb_offset_q <= wb_offset_d;
      l_q         <= l_d;
      w_q         <= w_d;
      pc_q        <= pc_d;
      wb_vld_q    <= wb_vld_d;
    end
  end

  assign bus.o_ldm_hold      = hold_c;
  assign bus.o_ldm_mem_vld   = busy_c;
  assign bus.o_ldm_reg_code  = idx_c;
  assign bus.o_ldm_offset    = offset_q;
  assign bus.o_ldm_l         = l_q;
  assign bus.o_ldm_last      = busy_c && single_c;
  assign bus.o_ldm_flushreq  = last_fire_c && l_q && pc_q;
  assign bus.o_ldm_wb_vld    = wb_vld_q;
  assign bus.o_ldm_wb_offset = wb_offset_q;

endmodule

// File: tb/tb_ldm_seq.sv
// Bench for ldm_seq: directed scenarios plus randomized instructions against a beat-list reference model.
module tb_ldm_seq;

  localparam int unsigned NREG   = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WB     = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  ldm_seq_if #(.NREG(NREG), .ADDR_W(ADDR_W)) bus ();

  ldm_seq #(.NREG(NREG), .ADDR_W(ADDR_W), .WORD_BYTES(WB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  code;
    logic [31:0] off;
    logic        l;
    logic        flush;
  } beat_t;

  int errors = 0;
  int checks = 0;

  beat_t       exp_q[$];
  logic        cur_w;
  logic [31:0] cur_wb;
  int          cur_n;
  logic        wb_exp = 1'b0;
  logic [31:0] wb_exp_off = '0;
  logic        accepted;
  int          dut_fires;
  int          cyc = 0;

  logic [3:0]  log_code[$];
  logic [31:0] log_off[$];
  int          log_cyc[$];
  int          hold_seen, flush_seen, wb_seen;
  logic [31:0] wb_seen_off;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_code.delete(); log_off.delete(); log_cyc.delete();
    hold_seen = 0; flush_seen = 0; wb_seen = 0; wb_seen_off = '0;
  endtask

  // Expected beats: k-th listed register (ascending) at lowest_address + k*WB.
  task automatic load(input logic p, input logic u, input logic l, input logic w,
                      input logic [15:0] list);
    int n, k;
    logic [31:0] lo;
    n = $countones(list);
    if (u) lo = p ? 32'(WB) : 32'd0;
    else   lo = 32'(p ? 0 : WB) - 32'(n * WB);
    k = 0;
    for (int r = 0; r < NREG; r++) begin
      if (list[r]) begin
        exp_q.push_back('{code: 4'(r), off: lo + 32'(k * WB), l: l, flush: (l && r == NREG - 1)});
        k++;
      end
    end
    cur_w     = w;
    cur_n     = n;
    cur_wb    = u ? 32'(n * WB) : (32'd0 - 32'(n * WB));
    dut_fires = 0;
  endtask

  task automatic set_instr(input logic vld, input logic p, input logic u, input logic l,
                           input logic w, input logic [15:0] list);
    bus.i_ldm_vld = vld; bus.i_ldm_p = p; bus.i_ldm_u = u;
    bus.i_ldm_l = l; bus.i_ldm_w = w; bus.i_reglist = list;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic cycle();
    logic fire_e, last_e, hold_e, acc, wb_next, dut_fire;
    logic [31:0] wb_next_off;
    int sz;
    #1;
    sz = exp_q.size();
    chk("wb_vld", 32'(bus.o_ldm_wb_vld), 32'(wb_exp));
    if (wb_exp) chk("wb_offset", bus.o_ldm_wb_offset, wb_exp_off);
    chk("mem_vld", 32'(bus.o_ldm_mem_vld), 32'(sz > 0));
    if (sz > 0) begin
      chk("reg_code", 32'(bus.o_ldm_reg_code), 32'(exp_q[0].code));
      chk("offset", bus.o_ldm_offset, exp_q[0].off);
      chk("dir_l", 32'(bus.o_ldm_l), 32'(exp_q[0].l));
      chk("last", 32'(bus.o_ldm_last), 32'(sz == 1));
    end
    fire_e = (sz > 0) && bus.i_mem_rdy && en;
    last_e = fire_e && (sz == 1);
    hold_e = (sz > 0) && !last_e;
    chk("hold", 32'(bus.o_ldm_hold), 32'(hold_e));
    chk("flushreq", 32'(bus.o_ldm_flushreq), 32'(fire_e && exp_q[0].flush));

    dut_fire = bus.o_ldm_mem_vld && bus.i_mem_rdy && en;
    if (dut_fire === 1'b1) begin
      log_code.push_back(bus.o_ldm_reg_code);
      log_off.push_back(bus.o_ldm_offset);
      log_cyc.push_back(cyc);
      dut_fires++;
    end
    if (bus.o_ldm_hold === 1'b1) hold_seen++;
    if (bus.o_ldm_flushreq === 1'b1) flush_seen++;
    if (bus.o_ldm_wb_vld === 1'b1) begin wb_seen++; wb_seen_off = bus.o_ldm_wb_offset; end

    acc = en && bus.i_ldm_vld && !hold_e;
    wb_next = 1'b0;
    wb_next_off = '0;
    if (fire_e) begin
      if (last_e) begin
        chk("beat_count", 32'(dut_fires), 32'(cur_n));
        if (cur_w) begin wb_next = 1'b1; wb_next_off = cur_wb; end
      end
      void'(exp_q.pop_front());
    end
    if (acc) begin
      load(bus.i_ldm_p, bus.i_ldm_u, bus.i_ldm_l, bus.i_ldm_w, bus.i_reglist);
      accepted = 1'b1;
      if (cur_n == 0 && cur_w) begin wb_next = 1'b1; wb_next_off = '0; end
    end
    @(posedge clk);
    wb_exp = wb_next;
    wb_exp_off = wb_next_off;
    cyc++;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_vld"}, 32'(bus.o_ldm_mem_vld), 32'd0);
    chk({tag, "_hold"}, 32'(bus.o_ldm_hold), 32'd0);
    chk({tag, "_code"}, 32'(bus.o_ldm_reg_code), 32'd0);
    chk({tag, "_offset"}, bus.o_ldm_offset, 32'd0);
    chk({tag, "_l"}, 32'(bus.o_ldm_l), 32'd0);
    chk({tag, "_last"}, 32'(bus.o_ldm_last), 32'd0);
    chk({tag, "_flush"}, 32'(bus.o_ldm_flushreq), 32'd0);
    chk({tag, "_wb_vld"}, 32'(bus.o_ldm_wb_vld), 32'd0);
    chk({tag, "_wb_off"}, bus.o_ldm_wb_offset, 32'd0);
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [3:0] code,
                          input logic [31:0] off);
    if (log_code.size() > i) begin
      chk({tag, "_code"}, 32'(log_code[i]), 32'(code));
      chk({tag, "_off"}, log_off[i], off);
    end else begin
      chk({tag, "_present"}, 32'(log_code.size()), 32'(i + 1));
    end
  endtask

  initial begin
    logic [15:0] list;
    logic p, u, l, w;
    int guard;

    rst_n = 1'b0;
    en = 1'b0;
    bus.i_mem_rdy = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    en = 1'b1;
    bus.i_mem_rdy = 1'b1;

    // IA 0x0005 with writeback
    clear_logs();
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005); cycle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) cycle();
    chk("ia_beats", 32'(log_code.size()), 32'd2);
    chk_beat("ia_b0", 0, 4'd0, 32'h0);
    chk_beat("ia_b1", 1, 4'd2, 32'h4);
    chk("ia_hold_cycles", 32'(hold_seen), 32'd1);
    chk("ia_wb_cnt", 32'(wb_seen), 32'd1);
    chk("ia_wb_off", wb_seen_off, 32'd8);

    // DB 0x8003 load with PC
    clear_logs();
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8003); cycle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (4) cycle();
    chk("db_beats", 32'(log_code.size()), 32'd3);
    chk_beat("db_b0", 0, 4'd0, 32'hFFFF_FFF4);
    chk_beat("db_b1", 1, 4'd1, 32'hFFFF_FFF8);
    chk_beat("db_b2", 2, 4'd15, 32'hFFFF_FFFC);
    chk("db_flush_cnt", 32'(flush_seen), 32'd1);
    chk("db_wb_off", wb_seen_off, 32'hFFFF_FFF4);

    // DA and IB 0x0005
    clear_logs();
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005); cycle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) cycle();
    chk_beat("da_b0", 0, 4'd0, 32'hFFFF_FFFC);
    chk_beat("da_b1", 1, 4'd2, 32'h0);
    clear_logs();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0005); cycle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) cycle();
    chk_beat("ib_b0", 0, 4'd0, 32'h4);
    chk_beat("ib_b1", 1, 4'd2, 32'h8);

    // Memory back-pressure, then enable low, for 3 cycles mid-sequence
    for (int k = 0; k < 2; k++) begin
      clear_logs();
      set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0007); cycle();
      set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      cycle();
      if (k == 0) bus.i_mem_rdy = 1'b0; else en = 1'b0;
      repeat (3) cycle();
      bus.i_mem_rdy = 1'b1; en = 1'b1;
      repeat (3) cycle();
      chk(k == 0 ? "stall_rdy_beats" : "stall_en_beats", 32'(log_code.size()), 32'd3);
      chk_beat(k == 0 ? "stall_rdy_b1" : "stall_en_b1", 1, 4'd1, 32'h4);
      chk(k == 0 ? "stall_rdy_hold" : "stall_en_hold", 32'(hold_seen), 32'd5);
      if (log_cyc.size() > 1)
        chk(k == 0 ? "stall_rdy_gap" : "stall_en_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd4);
    end

    // Back-to-back IA 0x0003 then IA 0x0010
    clear_logs();
    accepted = 1'b0;
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0003); cycle();
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
    accepted = 1'b0;
    cycle(); cycle();
    chk("b2b_accept", 32'(accepted), 32'd1);
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) cycle();
    chk("b2b_beats", 32'(log_code.size()), 32'd3);
    chk_beat("b2b_b2", 2, 4'd4, 32'h0);
    if (log_cyc.size() > 2) chk("b2b_span", 32'(log_cyc[2] - log_cyc[0]), 32'd2);

    // Empty list with writeback
    clear_logs();
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000); cycle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) cycle();
    chk("empty_beats", 32'(log_code.size()), 32'd0);
    chk("empty_hold", 32'(hold_seen), 32'd0);
    chk("empty_wb_cnt", 32'(wb_seen), 32'd1);
    chk("empty_wb_off", wb_seen_off, 32'd0);

    // Reset after 2 of 5 beats
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h001F); cycle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    wb_exp = 1'b0;
    @(posedge clk); @(posedge clk); cyc += 2;
    #1;
    chk_zero("midrst_hold");
    rst_n = 1'b1;
    clear_logs();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002); cycle();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) cycle();
    chk("postrst_beats", 32'(log_code.size()), 32'd1);
    chk_beat("postrst_b0", 0, 4'd1, 32'h4);

    // Randomized instructions against the model
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: list = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'(1 << $urandom_range(0, 15));
        1: list = 16'($urandom);
        2: list = 16'($urandom) & 16'($urandom);
        default: list = 16'($urandom) | 16'h8000;
      endcase
      p = 1'($urandom); u = 1'($urandom); l = 1'($urandom); w = 1'($urandom);
      if (list == 16'h0) w = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        set_instr(1'b0, p, u, l, w, list);
        en = ($urandom_range(0, 9) != 0);
        bus.i_mem_rdy = ($urandom_range(0, 3) != 0);
        cycle();
      end
      set_instr(1'b1, p, u, l, w, list);
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 500) begin
        en = ($urandom_range(0, 9) != 0);
        bus.i_mem_rdy = ($urandom_range(0, 3) != 0);
        cycle();
        guard++;
      end
      if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    end
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    guard = 0;
    while ((exp_q.size() > 0 || wb_exp) && guard < 500) begin
      en = ($urandom_range(0, 9) != 0);
      bus.i_mem_rdy = ($urandom_range(0, 3) != 0);
      cycle();
      guard++;
    end
    cycle();
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
